// File: rtl/cdu_pkg.sv
// Shared types and constants for the CDU angle counter.
// The angle register is binary-weighted over one full turn of the shaft.
package cdu_pkg;

  localparam int unsigned ANGLE_WIDTH = 15;

  // One angle LSB is 360 deg / 2^ANGLE_WIDTH, about 39.551 arc-seconds.
  localparam int unsigned ANGLE_LSB_MILLIARCSEC = 39551;

  // Wide enough for the largest legal FILTER value (15).
  localparam int unsigned FILTER_CNT_WIDTH = 4;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } filt_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/cdu_angle_counter_if.sv
// Four-phase snapshot read port of the CDU angle counter.
// The master raises rd_req; the slave answers with rd_ack and a frozen rd_data.
interface cdu_angle_counter_if
  import cdu_pkg::*;
#(
  parameter int unsigned WIDTH = ANGLE_WIDTH
);

  logic             rd_req;
  logic             rd_ack;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output rd_req,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    output rd_ack,
    output rd_data
  );

endinterface

// File: rtl/cdu_pulse_filter.sv
// Synchronizes one asynchronous level and turns each sufficiently long high
// pulse into a single-cycle accept, re-arming only after an equally long low.
module cdu_pulse_filter
  import cdu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic accept_o
);

  localparam logic [FILTER_CNT_WIDTH-1:0] CntLast = FILTER_CNT_WIDTH'(FILTER - 1);
  localparam logic [FILTER_CNT_WIDTH-1:0] CntOne  = FILTER_CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        level_s;
  filt_state_e                 state_q, state_d;
  logic [FILTER_CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign level_s = sync_q[SYNC_STAGES-1];

  // The accept is combinational so the top can apply it on the same edge that
  // completes the run; this keeps the total latency at SYNC_STAGES+FILTER-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (level_s) begin
          if (cnt_q == CntLast) begin
            accept_o = 1'b1;
            state_d  = FIRED;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      FIRED: begin
        if (!level_s) begin
          if (cnt_q == CntLast) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ARMED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= ARMED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], level_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cdu_angle_counter.sv
// Receiving end of the CDU error-angle up/down interface: filters AUPLVL/ADNLVL,
// accumulates the shaft angle, forwards count strobes and serves snapshots.
module cdu_angle_counter
  import cdu_pkg::*;
#(
  parameter int unsigned WIDTH       = ANGLE_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 3
) (
  input  logic                 CLOCKH,
  input  logic                 rst,
  input  logic                 AUPLVL,
  input  logic                 ADNLVL,
  input  logic                 CCDUZ,
  cdu_angle_counter_if.slave   rd,
  output logic                 PCDU,
  output logic                 MCDU,
  output logic                 coinc,
  output logic [WIDTH-1:0]     angle
);

  localparam logic [WIDTH-1:0] AngleOne = WIDTH'(1);

  logic                   up_acc, dn_acc;
  logic [SYNC_STAGES-1:0] zero_sync_q, rdreq_sync_q;
  logic                   zero_s, rdreq_s;

  logic [WIDTH-1:0] angle_q, angle_d;
  logic             pcdu_q, pcdu_d;
  logic             mcdu_q, mcdu_d;
  logic             coinc_q, coinc_d;

  rd_state_e        rd_state_q, rd_state_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  cdu_pulse_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER)
  ) u_up_filter (
    .clk_i    (CLOCKH),
    .rst_i    (rst),
    .level_i  (AUPLVL),
    .accept_o (up_acc)
  );

  cdu_pulse_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER)
  ) u_dn_filter (
    .clk_i    (CLOCKH),
    .rst_i    (rst),
    .level_i  (ADNLVL),
    .accept_o (dn_acc)
  );

  assign zero_s  = zero_sync_q[SYNC_STAGES-1];
  assign rdreq_s = rdreq_sync_q[SYNC_STAGES-1];

  // Zero dominates: an accept landing while CCDUZ is high is dropped, not deferred.
  always_comb begin
    angle_d = angle_q;
    pcdu_d  = 1'b0;
    mcdu_d  = 1'b0;
    coinc_d = 1'b0;
    if (zero_s) begin
      angle_d = '0;
    end else begin
      unique case ({up_acc, dn_acc})
        2'b10: begin
          angle_d = angle_q + AngleOne;
          pcdu_d  = 1'b1;
        end
        2'b01: begin
          angle_d = angle_q - AngleOne;
          mcdu_d  = 1'b1;
        end
        2'b11: coinc_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Snapshot takes the post-update angle so a reader sees this edge's count.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_data_d  = rd_data_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (rdreq_s) begin
          rd_data_d  = angle_d;
          rd_state_d = RD_ACK;
        end
      end
      RD_ACK: begin
        if (!rdreq_s) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      zero_sync_q  <= '0;
      rdreq_sync_q <= '0;
      angle_q      <= '0;
      pcdu_q       <= 1'b0;
      mcdu_q       <= 1'b0;
      coinc_q      <= 1'b0;
      rd_state_q   <= RD_IDLE;
      rd_data_q    <= '0;
    end else begin
      zero_sync_q  <= {zero_sync_q[SYNC_STAGES-2:0], CCDUZ};
      rdreq_sync_q <= {rdreq_sync_q[SYNC_STAGES-2:0], rd.rd_req};
      angle_q      <= angle_d;
      pcdu_q       <= pcdu_d;
      mcdu_q       <= mcdu_d;
      coinc_q      <= coinc_d;
      rd_state_q   <= rd_state_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign angle      = angle_q;
  assign PCDU       = pcdu_q;
  assign MCDU       = mcdu_q;
  assign coinc      = coinc_q;
  assign rd.rd_ack  = (rd_state_q == RD_ACK);
  assign rd.rd_data = rd_data_q;

endmodule

// File: tb/tb_cdu_angle_counter.sv
// Bench for cdu_angle_counter: hand sequences, a vector table and random
// stimulus, every cycle compared with a sample-history reference model.
module tb_cdu_angle_counter;

  localparam int W  = 15;
  localparam int SS = 2;
  localparam int F  = 3;
  localparam int HL = SS + F;
  localparam int FULL = 1 << W;

  logic         clk = 1'b0;
  logic         rst_t;
  logic         au, ad, z;
  logic         PCDU, MCDU, coinc;
  logic [W-1:0] angle;

  int total = 0;
  int bad   = 0;

  cdu_angle_counter_if #(.WIDTH(W)) rd_if ();

  cdu_angle_counter #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .FILTER      (F)
  ) dut (
    .CLOCKH (clk),
    .rst    (rst_t),
    .AUPLVL (au),
    .ADNLVL (ad),
    .CCDUZ  (z),
    .rd     (rd_if),
    .PCDU   (PCDU),
    .MCDU   (MCDU),
    .coinc  (coinc),
    .angle  (angle)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge; index 0 is the newest sample.
  logic [HL-1:0] hu, hd, hz, hr;
  bit arm_u, arm_d;
  int m_angle, m_data;
  bit m_ack, m_p, m_m, m_c;

  task automatic model_edge();
    bit acc_u, acc_d, zs, rs;
    if (rst_t) begin
      hu = '0; hd = '0; hz = '0; hr = '0;
      arm_u = 1; arm_d = 1;
      m_angle = 0; m_data = 0; m_ack = 0;
      m_p = 0; m_m = 0; m_c = 0;
    end else begin
      hu = {hu[HL-2:0], au};
      hd = {hd[HL-2:0], ad};
      hz = {hz[HL-2:0], z};
      hr = {hr[HL-2:0], rd_if.rd_req};
      // A pulse counts once F delayed samples in a row are high; F lows re-arm.
      acc_u = arm_u && (&hu[HL-1:SS]);
      acc_d = arm_d && (&hd[HL-1:SS]);
      if (acc_u) arm_u = 0; else if (!arm_u && !(|hu[HL-1:SS])) arm_u = 1;
      if (acc_d) arm_d = 0; else if (!arm_d && !(|hd[HL-1:SS])) arm_d = 1;
      zs = hz[SS];
      rs = hr[SS];
      m_p = 0; m_m = 0; m_c = 0;
      if (zs) m_angle = 0;
      else if (acc_u && acc_d) m_c = 1;
      else if (acc_u) begin m_angle = (m_angle + 1) % FULL; m_p = 1; end
      else if (acc_d) begin m_angle = (m_angle + FULL - 1) % FULL; m_m = 1; end
      if (!m_ack && rs) begin m_ack = 1; m_data = m_angle; end
      else if (m_ack && !rs) m_ack = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  int np, nm, nc;

  task automatic step();
    logic [63:0] act, exp;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    act = 64'({angle, rd_if.rd_ack, rd_if.rd_data, PCDU, MCDU, coinc});
    exp = 64'({W'(m_angle), m_ack, W'(m_data), m_p, m_m, m_c});
    check($sformatf("model_cycle%0d", cyc), act, exp);
    np += int'(PCDU);
    nm += int'(MCDU);
    nc += int'(coinc);
  endtask

  typedef struct {
    bit rst, up, dn, zr, rr;
    int cycles;
    int angle;
    bit ack;
    int data;
    int np, nm, nc;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit r, u, d, zz, q, input int n, a, input bit k,
                      input int dat, p, m, c);
    vec_t v;
    v.rst = r; v.up = u; v.dn = d; v.zr = zz; v.rr = q; v.cycles = n;
    v.angle = a; v.ack = k; v.data = dat; v.np = p; v.nm = m; v.nc = c;
    vecs.push_back(v);
  endtask

  initial begin
    rst_t = 1; au = 0; ad = 0; z = 0; rd_if.rd_req = 0;
    np = 0; nm = 0; nc = 0;

    //    rst up dn z  rr  cyc  angle    ack data p m c
    addv(1, 0, 0, 0, 0, 3,   0,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   1,       0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 6,   1,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   2,       0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 6,   2,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   3,       0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 6,   3,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   4,       0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 6,   4,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   5,       0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 6,   5,       0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 6,   4,       0, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 0, 6,   4,       0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 6,   3,       0, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 0, 6,   3,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2,   3,       0, 0, 0, 0, 0);  // glitch
    addv(0, 0, 0, 0, 0, 6,   3,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 3,   3,       0, 0, 0, 0, 0);  // minimum pulse
    addv(0, 0, 0, 0, 0, 6,   4,       0, 0, 1, 0, 0);
    addv(0, 1, 1, 0, 0, 6,   4,       0, 0, 0, 0, 1);  // coincidence
    addv(0, 0, 0, 0, 0, 6,   4,       0, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 4,   0,       0, 0, 0, 0, 0);  // zero command
    addv(0, 0, 0, 0, 0, 4,   0,       0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 6,   'h7FFF,  0, 0, 0, 1, 0);  // wrap down
    addv(0, 0, 0, 0, 0, 6,   'h7FFF,  0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   0,       0, 0, 1, 0, 0);  // wrap up
    addv(0, 0, 0, 0, 0, 6,   0,       0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 6,   1,       0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 6,   1,       0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 1, 4,   1,       1, 1, 0, 0, 0);  // capture
    addv(0, 1, 0, 0, 1, 6,   2,       1, 1, 1, 0, 0);  // count while frozen
    addv(0, 0, 0, 0, 1, 6,   2,       1, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 4,   2,       0, 1, 0, 0, 0);  // release
    addv(0, 0, 0, 0, 1, 4,   2,       1, 2, 0, 0, 0);  // fresh capture
    addv(1, 0, 0, 0, 1, 1,   0,       0, 0, 0, 0, 0);  // reset mid-handshake
    addv(0, 0, 0, 0, 1, 4,   0,       1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 4,   0,       0, 0, 0, 0, 0);

    // Reset state.
    repeat (3) step();
    check("reset_angle", 64'(angle), 64'd0);
    check("reset_rd_ack", 64'(rd_if.rd_ack), 64'd0);
    check("reset_rd_data", 64'(rd_if.rd_data), 64'd0);
    check("reset_strobes", 64'({PCDU, MCDU, coinc}), 64'd0);

    // Held level: one PCDU on the 4th edge after the first sample, none after.
    rst_t = 0;
    au = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("hold_pcdu_edge%0d", i), 64'(PCDU), (i == 5) ? 64'd1 : 64'd0);
    end
    check("hold_angle", 64'(angle), 64'd1);
    au = 0;
    repeat (6) step();

    foreach (vecs[k]) begin
      rst_t = vecs[k].rst; au = vecs[k].up; ad = vecs[k].dn;
      z = vecs[k].zr; rd_if.rd_req = vecs[k].rr;
      np = 0; nm = 0; nc = 0;
      repeat (vecs[k].cycles) step();
      check($sformatf("vec%0d_angle", k), 64'(angle), 64'(vecs[k].angle));
      check($sformatf("vec%0d_rd_ack", k), 64'(rd_if.rd_ack), 64'(vecs[k].ack));
      check($sformatf("vec%0d_rd_data", k), 64'(rd_if.rd_data), 64'(vecs[k].data));
      check($sformatf("vec%0d_counts", k), 64'({8'(np), 8'(nm), 8'(nc)}),
            64'({8'(vecs[k].np), 8'(vecs[k].nm), 8'(vecs[k].nc)}));
    end
    rst_t = 0; au = 0; ad = 0; z = 0; rd_if.rd_req = 0;

    // Zero command landing on the same edge as an up accept.
    au = 1; repeat (6) step();
    au = 0; repeat (6) step();
    check("zc_pre_angle", 64'(angle), 64'd1);
    au = 1;
    step();
    step();
    z = 1;
    step();
    z = 0;
    step();
    check("zc_before_angle", 64'(angle), 64'd1);
    step();
    check("zc_angle", 64'(angle), 64'd0);
    check("zc_strobes", 64'({PCDU, MCDU, coinc}), 64'd0);
    repeat (4) step();
    au = 0;
    repeat (8) step();
    check("zc_not_deferred", 64'(angle), 64'd0);

    // Random stimulus against the model.
    for (int s = 0; s < 400; s++) begin
      rst_t = ($urandom_range(0, 63) == 0);
      au = 1'($urandom_range(0, 1));
      ad = 1'($urandom_range(0, 1));
      z  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rd_if.rd_req = ~rd_if.rd_req;
      repeat ($urandom_range(1, 8)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdu_angle_counter.md
Name: cdu_angle_counter

Overview:
- Receiving end of the CDU error-angle up/down level interface; consumes AUPLVL/ADNLVL pulse trains and turns them into a registered shaft-angle count.
- Each accepted pulse moves the angle by one LSB: 360 deg / 2^WIDTH, which is 39.55 arc-seconds at the default width.
- Forwards one-cycle PCDU/MCDU count strobes toward the AGC counter side.
- Provides a four-phase snapshot read port and honours the CCDUZ zero command.
- Sits beside the CDU top level, on the AGC clock domain.

Parameters:
- WIDTH, 15: angle register width in bits; full scale equals 360 deg.
- SYNC_STAGES, 2: synchronizer flops on each asynchronous input; legal range 2..4.
- FILTER, 3: consecutive synchronized-high cycles needed to accept a pulse. The same number of low cycles is needed to re-arm. Legal range 1..15.

Ports:
- CLOCKH  in  1  AGC clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- AUPLVL  in  1  asynchronous up-count level from the error-angle logic.
- ADNLVL  in  1  asynchronous down-count level from the error-angle logic.
- CCDUZ  in  1  zero-counter command; asynchronous, synchronized internally.
- rd_req  in  1  snapshot request; four-phase level.
- rd_ack  out  1  snapshot valid / acknowledge.
- rd_data  out  WIDTH  captured angle; held stable while rd_ack=1.
- PCDU  out  1  one-cycle strobe: net +1 applied this edge.
- MCDU  out  1  one-cycle strobe: net -1 applied this edge.
- coinc  out  1  one-cycle strobe: up and down accepted together, net 0 applied.
- angle  out  WIDTH  live angle register.

Behaviour:
- Clock and reset:
  - Single clock CLOCKH. Reset is synchronous and active-high on rst.
  - While rst=1 all outputs are 0: angle, rd_data, rd_ack, PCDU, MCDU, coinc. All synchronizers, filter counters and armed flags also clear.
  - Reset asserted mid-handshake drops rd_ack on the next edge. Any pulse partially filtered at that time is discarded.
- Synchronizers: AUPLVL, ADNLVL, CCDUZ and rd_req each pass through a SYNC_STAGES flop chain. All further logic uses only the synchronized signals.
- Pulse filter: one per direction, identical, two states.
  - ARMED: sync-high increments the counter and sync-low clears it. When the counter reaches FILTER, raise the accept strobe for one cycle and go to FIRED.
  - FIRED: sync-low increments the counter and sync-high clears it. When the counter reaches FILTER, go to ARMED; no strobe.
  - Pulses shorter than FILTER synchronized cycles are ignored. A level held high counts exactly once.
- Latency: with the input high from sampling edge k, the accept strobe, PCDU/MCDU and the angle update all occur on edge k+SYNC_STAGES+FILTER-1. With defaults that is edge k+4.
- Accumulation:
  - Up only: angle <= angle+1 mod 2^WIDTH, PCDU=1.
  - Down only: angle <= angle-1 mod 2^WIDTH, MCDU=1.
  - Both on the same edge: angle unchanged, coinc=1, PCDU=MCDU=0.
  - Wrap-around is silent: all-ones + 1 gives 0, and 0 - 1 gives all-ones.
- Zero command: synchronized CCDUZ=1 forces angle <= 0 on every edge it is high. It dominates any accept that cycle; PCDU, MCDU and coinc are suppressed. Filters keep running, so a pulse accepted during CCDUZ is lost, not deferred.
- Read handshake (four-phase): two states, IDLE and ACK.
  - IDLE: on sync rd_req=1, set rd_data <= the angle value after that edge's update, set rd_ack <= 1, go to ACK.
  - ACK: rd_data is frozen. When sync rd_req=0, set rd_ack <= 0 and return to IDLE.
  - A new capture requires rd_req to go low and then high again.
  - The angle keeps counting during ACK.

Decomposition:
- Shared package cdu_pkg holds:
  - ANGLE_WIDTH = 15.
  - The LSB-weight comment constant.
  - Filter state enum {ARMED, FIRED}.
  - Read state enum {RD_IDLE, RD_ACK}.
- One sub-module is natural: cdu_pulse_filter, containing the synchronizer, counter and ARMED/FIRED state. It is instantiated twice, once for up and once for down. CCDUZ and rd_req use plain synchronizers.

Test Plan:
- Reset, then AUPLVL high for 10 cycles -> single PCDU on the 4th edge after the first sample; angle=1; no further strobes while held high.
- 5 clean up pulses (6 high / 6 low each), then 2 down pulses -> angle=3; 5 PCDU and 2 MCDU strobes.
- AUPLVL glitch of 2 cycles high -> no PCDU; angle unchanged. A 3-cycle pulse -> counted.
- Preload 0x7FFF via 32767 up pulses (or a forced init), then 1 up -> angle=0x0000. Then 1 down -> 0x7FFF.
- AUPLVL and ADNLVL rise on the same edge -> coinc=1 for one cycle; angle unchanged; PCDU=MCDU=0.
- Angle=100, raise rd_req -> rd_ack=1 with rd_data=100. Apply 4 up pulses while rd_req is held -> rd_data stays 100 and angle=104. Drop rd_req -> rd_ack=0. Also assert CCDUZ coincident with an up accept -> angle=0 and PCDU=0.
